steve_health: RTL and testbench

- Player-side endpoint of the mob-shot event stream: consumes the per-cycle shooter index emitted by the mob controller and tracks Steve's hit points.
- Applies damage with an invulnerability window and regenerates slowly; declares death and produces the `alive` level and the one-cycle `respawn` pulse that the mob controller and the game logic consume.
- Sits between the mob controller and the HUD/renderer.

---
 rtl/game_pkg.sv | 27 ++
 rtl/cycle_timer.sv | 39 +++
 rtl/steve_health.sv | 130 +++++++++++++
 tb/tb_steve_health.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, widths and default timing constants for the game blocks.
package game_pkg;

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD, RESPAWN} health_state_t;

  localparam int HP_W  = 5;
  localparam int TMR_W = 32;

  localparam int unsigned DEF_MAX_HP        = 20;
  localparam int unsigned DEF_DAMAGE        = 3;
  localparam int unsigned DEF_INVULN_CYCLES = 25_000_000;
  localparam int unsigned DEF_REGEN_CYCLES  = 100_000_000;
  localparam int unsigned DEF_DEAD_HOLD     = 50_000_000;

  // Health never wraps below zero: a hit bigger than what is left just empties it.
  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                   input int unsigned dmg);
    if (32'(hp) > dmg) return hp - HP_W'(dmg);
    return '0;
  endfunction

  function automatic logic [HP_W-1:0] hp_after_regen(input logic [HP_W-1:0] hp,
                                                     input logic [HP_W-1:0] max_hp);
    return (hp < max_hp) ? hp + HP_W'(1) : max_hp;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// 32-bit cycle counter with clear/load/enable; counts down to 0 or up to LIMIT
// and raises tc while sitting at its terminal value.
module cycle_timer
  import game_pkg::*;
#(
  parameter bit               DOWN  = 1'b0,
  parameter logic [TMR_W-1:0] LIMIT = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [TMR_W-1:0] load_value,
  input  logic             en,
  output logic             tc
);

  logic [TMR_W-1:0] count;

  // Clear beats load beats enable; the count parks at its terminal value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      if (DOWN) begin
        if (count != '0) count <= count - TMR_W'(1);
      end else begin
        if (count != LIMIT) count <= count + TMR_W'(1);
      end
    end
  end

  assign tc = DOWN ? (count == '0) : (count == LIMIT);

endmodule

// File: rtl/steve_health.sv
// Steve's hit-point tracker: takes mob shots, runs invulnerability, regen and
// death/respawn sequencing, and drives the alive/respawn handshake to the mobs.
module steve_health
  import game_pkg::*;
#(
  parameter int unsigned MAX_HP        = DEF_MAX_HP,
  parameter int unsigned DAMAGE        = DEF_DAMAGE,
  parameter int unsigned INVULN_CYCLES = DEF_INVULN_CYCLES,
  parameter int unsigned REGEN_CYCLES  = DEF_REGEN_CYCLES,
  parameter int unsigned DEAD_HOLD     = DEF_DEAD_HOLD
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [7:0]      who_shoot,
  input  logic            respawn_btn,
  output logic [HP_W-1:0] health,
  output logic            alive,
  output logic            respawn,
  output logic            hit_flash,
  output logic [7:0]      last_hitter
);

  localparam logic [HP_W-1:0]  MAX_HP_V    = HP_W'(MAX_HP);
  localparam logic [TMR_W-1:0] INVULN_LOAD = (INVULN_CYCLES == 0) ? '0 : TMR_W'(INVULN_CYCLES - 1);
  localparam logic [TMR_W-1:0] REGEN_LAST  = TMR_W'(REGEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] DEAD_LIMIT  = TMR_W'(DEAD_HOLD);

  health_state_t   state;
  logic            btn_prev;
  logic            shot;
  logic            btn_rise;
  logic [HP_W-1:0] hit_hp;
  logic            invuln_tc;
  logic            regen_tc;
  logic            dead_tc;

  assign shot     = (who_shoot != 8'h00);
  assign btn_rise = respawn_btn & ~btn_prev;
  assign hit_hp   = hp_after_hit(health, DAMAGE);

  // INVULN_CYCLES=0 still loads 0, which gives a single-cycle immunity window.
  cycle_timer #(.DOWN(1'b1), .LIMIT('0)) u_invuln_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (state == DEAD || state == RESPAWN),
    .load       (state == ALIVE && shot),
    .load_value (INVULN_LOAD),
    .en         (state == INVULN),
    .tc         (invuln_tc)
  );

  cycle_timer #(.DOWN(1'b0), .LIMIT(REGEN_LAST)) u_regen_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (state != ALIVE || shot || regen_tc),
    .load       (1'b0),
    .load_value ('0),
    .en         (state == ALIVE),
    .tc         (regen_tc)
  );

  cycle_timer #(.DOWN(1'b0), .LIMIT(DEAD_LIMIT)) u_dead_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (state != DEAD),
    .load       (1'b0),
    .load_value ('0),
    .en         (state == DEAD),
    .tc         (dead_tc)
  );

  // Every output is a register; alive rises one cycle after the respawn pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ALIVE;
      health      <= MAX_HP_V;
      alive       <= 1'b1;
      respawn     <= 1'b0;
      hit_flash   <= 1'b0;
      last_hitter <= 8'h00;
      btn_prev    <= 1'b0;
    end else begin
      btn_prev <= respawn_btn;
      respawn  <= 1'b0;
      case (state)
        ALIVE: begin
          if (shot) begin
            last_hitter <= who_shoot;
            health      <= hit_hp;
            if (hit_hp == '0) begin
              state     <= DEAD;
              alive     <= 1'b0;
              hit_flash <= 1'b0;
            end else begin
              state     <= INVULN;
              hit_flash <= 1'b1;
            end
          end else if (regen_tc) begin
            health <= hp_after_regen(health, MAX_HP_V);
          end
        end
        INVULN: begin
          if (invuln_tc) begin
            state     <= ALIVE;
            hit_flash <= 1'b0;
          end
        end
        DEAD: begin
          alive     <= 1'b0;
          hit_flash <= 1'b0;
          health    <= '0;
          if (dead_tc && btn_rise) begin
            state   <= RESPAWN;
            respawn <= 1'b1;
            health  <= MAX_HP_V;
          end
        end
        RESPAWN: begin
          state       <= ALIVE;
          alive       <= 1'b1;
          last_hitter <= 8'h00;
        end
        default: begin
          state <= ALIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_steve_health.sv
// Randomized self-checking bench for steve_health against a cycle-time model.
module tb_steve_health;

  localparam int MAX_HP    = 6;
  localparam int DAMAGE    = 2;
  localparam int INVULN    = 4;
  localparam int REGEN     = 10;
  localparam int DEAD_HOLD = 3;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] who_shoot;
  logic       respawn_btn;
  logic [4:0] health;
  logic       alive;
  logic       respawn;
  logic       hit_flash;
  logic [7:0] last_hitter;

  int checks = 0;
  int passed = 0;

  steve_health #(
    .MAX_HP(MAX_HP), .DAMAGE(DAMAGE), .INVULN_CYCLES(INVULN),
    .REGEN_CYCLES(REGEN), .DEAD_HOLD(DEAD_HOLD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .who_shoot(who_shoot), .respawn_btn(respawn_btn),
    .health(health), .alive(alive), .respawn(respawn), .hit_flash(hit_flash),
    .last_hitter(last_hitter)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  wire [15:0] obs = {health, alive, respawn, hit_flash, last_hitter};
  localparam logic [15:0] RESET_VEC = {5'd6, 1'b1, 1'b0, 1'b0, 8'h00};

  // Reference model: events are tracked as absolute edge numbers.
  int         cyc, m_health, flash_end, quiet_start, dead_since;
  bit         m_alive, m_resp, m_flash, m_dead, m_respawning, m_prev;
  logic [7:0] m_last;

  function automatic logic [15:0] exp_vec();
    return {5'(m_health), m_alive, m_resp, m_flash, m_last};
  endfunction

  task automatic model_reset();
    cyc = 0; m_health = MAX_HP; m_alive = 1; m_resp = 0; m_flash = 0;
    m_dead = 0; m_respawning = 0; m_prev = 0; m_last = 8'h00; quiet_start = 0;
  endtask

  task automatic model_edge(input logic [7:0] ws, input logic btn);
    cyc++;
    m_resp = 0;
    if (m_respawning) begin
      m_respawning = 0; m_alive = 1; m_last = 8'h00; quiet_start = cyc;
    end else if (m_dead) begin
      if (btn && !m_prev && (cyc - dead_since) > DEAD_HOLD) begin
        m_dead = 0; m_respawning = 1; m_resp = 1; m_health = MAX_HP;
      end
    end else if (m_flash) begin
      if (cyc == flash_end) begin m_flash = 0; quiet_start = cyc; end
    end else if (ws != 8'h00) begin
      m_last   = ws;
      m_health = (m_health > DAMAGE) ? m_health - DAMAGE : 0;
      if (m_health == 0) begin
        m_dead = 1; m_alive = 0; dead_since = cyc;
      end else begin
        m_flash = 1; flash_end = cyc + ((INVULN > 0) ? INVULN : 1);
      end
    end else if ((cyc - quiet_start) % REGEN == 0) begin
      if (m_health < MAX_HP) m_health++;
    end
    m_prev = btn;
  endtask

  task automatic step(input logic [7:0] ws, input logic btn);
    who_shoot = ws; respawn_btn = btn;
    @(posedge Clk);
    model_edge(ws, btn);
    #1;
  endtask

  task automatic do_reset();
    who_shoot = 8'h00; respawn_btn = 1'b0; Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic hit_and_recover(input logic [7:0] ws);
    step(ws, 1'b0);
    repeat (INVULN) step(8'h00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== RESET_VEC) $display("[TB] FAIL reset_state: got %h want %h", obs, RESET_VEC);
    else passed++;
  endtask

  task automatic test_single_hit();
    do_reset();
    step(8'h2A, 1'b0);
    checks++;
    if (obs !== {5'd4, 1'b1, 1'b0, 1'b1, 8'h2A})
      $display("[TB] FAIL single_hit: got %h want %h", obs, {5'd4, 1'b1, 1'b0, 1'b1, 8'h2A});
    else passed++;
    for (int i = 1; i <= INVULN; i++) begin
      step(8'h00, 1'b0);
      checks++;
      if (hit_flash !== (i < INVULN))
        $display("[TB] FAIL flash_window[%0d]: got %b want %b", i, hit_flash, (i < INVULN));
      else passed++;
    end
  endtask

  task automatic test_held_shot();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(8'h05, 1'b0);
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL held_shot[%0d]: got %h want %h", i, obs, exp_vec());
      else passed++;
    end
    checks++;
    if ({health, last_hitter} !== {5'd2, 8'h05})
      $display("[TB] FAIL held_second_hit: got %h want %h", {health, last_hitter}, {5'd2, 8'h05});
    else passed++;
    step(8'h00, 1'b0);
  endtask

  task automatic test_death_respawn();
    do_reset();
    hit_and_recover(8'h31);
    hit_and_recover(8'h32);
    step(8'h33, 1'b0);
    checks++;
    if ({health, alive, hit_flash} !== {5'd0, 1'b0, 1'b0})
      $display("[TB] FAIL death: got %h want %h", {health, alive, hit_flash}, {5'd0, 1'b0, 1'b0});
    else passed++;
    step(8'h00, 1'b1);
    checks++;
    if (respawn !== 1'b0) $display("[TB] FAIL early_btn: got %b want 0", respawn);
    else passed++;
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    checks++;
    if ({respawn, alive, health} !== {1'b1, 1'b0, 5'd6})
      $display("[TB] FAIL respawn_pulse: got %h want %h", {respawn, alive, health}, {1'b1, 1'b0, 5'd6});
    else passed++;
    step(8'h00, 1'b0);
    checks++;
    if (obs !== RESET_VEC) $display("[TB] FAIL after_respawn: got %h want %h", obs, RESET_VEC);
    else passed++;
  endtask

  task automatic test_regen();
    do_reset();
    hit_and_recover(8'h11);
    hit_and_recover(8'h12);
    for (int k = 1; k <= 50; k++) begin
      step(8'h00, 1'b0);
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL regen_model[%0d]: got %h want %h", k, obs, exp_vec());
      else passed++;
      if (k % 10 == 0) begin
        checks++;
        if (health !== 5'(((2 + k / 10) < MAX_HP) ? 2 + k / 10 : MAX_HP))
          $display("[TB] FAIL regen_level[%0d]: got %0d", k, health);
        else passed++;
      end
    end
    hit_and_recover(8'h13);
    hit_and_recover(8'h14);
    repeat (REGEN - 1) step(8'h00, 1'b0);
    step(8'h15, 1'b0);
    checks++;
    if ({health, alive} !== {5'd0, 1'b0})
      $display("[TB] FAIL hit_beats_regen: got %h want %h", {health, alive}, {5'd0, 1'b0});
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(8'h44, 1'b0);
    step(8'h00, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) $display("[TB] FAIL reset_mid_invuln: got %h want %h", obs, RESET_VEC);
    else passed++;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    hit_and_recover(8'h45);
    hit_and_recover(8'h46);
    step(8'h47, 1'b0);
    step(8'h00, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) $display("[TB] FAIL reset_mid_dead: got %h want %h", obs, RESET_VEC);
    else passed++;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_btn_alive();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(8'h00, 1'(i % 2));
      checks++;
      if (obs !== RESET_VEC) $display("[TB] FAIL btn_alive[%0d]: got %h want %h", i, obs, RESET_VEC);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] ws;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ws = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      step(ws, 1'($urandom_range(0, 1)));
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      else passed++;
    end
  endtask

  initial begin
    Reset_n = 1'b0; who_shoot = 8'h00; respawn_btn = 1'b0;
    model_reset();
    test_reset();
    test_single_hit();
    test_held_shot();
    test_death_respawn();
    test_regen();
    test_async_reset();
    test_btn_alive();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
